eka_dmem_bridge: RTL and testbench
==================================

Name: eka_dmem_bridge

Overview:
- Data-side bridge between the Eka single-cycle core and the data memory/bus.
- Turns the core's single-cycle data request (data_addr, mem_wr_data, mem_wr, mem_rd) into a registered req/gnt/rvalid bus transaction.
- Holds the core with data_stall until the transaction completes, then presents the read data for exactly one un-stalled cycle.
- Adds misalignment detection and a response timeout so the core cannot hang.

Parameters:
- ADDR_WIDTH, 32, width of bus_addr; taken from data_addr[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 64, maximum cycles spent in REQ plus RESP before the access is aborted; must be at least 2.
- ERR_RDATA, 32'h0000_0000, value returned on mem_rd_data for an aborted or misaligned access.

Ports:
- clk  in  1  processor clock.
- reset  in  1  asynchronous, active-low reset.
- data_addr  in  32  core data address.
- mem_wr_data  in  32  core store data.
- mem_wr  in  1  core store request.
- mem_rd  in  1  core load request.
- mem_rd_data  out  32  load data to the core.
- data_stall  out  1  stalls the core PC.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  word-aligned bus address.
- bus_wdata  out  32  bus write data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  response valid (read data or write ack).
- bus_rdata  in  32  bus read data.
- fault  out  1  sticky flag: timeout or misaligned access; cleared only by reset.

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- Reset values (asynchronous, reset low):
  - bus_req, bus_we, fault = 0.
  - bus_addr, bus_wdata, mem_rd_data register = 0.
  - Timeout counter = 0.
- IDLE:
  - data_stall = mem_rd | mem_wr, combinational from the core inputs in the same cycle.
  - A request with data_addr[1:0] == 0:
    - Latch the address into bus_addr, mem_wr into bus_we, and mem_wr_data into bus_wdata.
    - Go to REQ.
  - If mem_wr and mem_rd are both set, the access is a write.
  - Misaligned request (data_addr[1:0] != 0):
    - No bus access.
    - Set fault, load ERR_RDATA into the rdata register, go to DONE.
  - No request: stay in IDLE, data_stall = 0.
- REQ:
  - bus_req = 1, and bus_addr/bus_we/bus_wdata are held stable until bus_gnt.
  - On bus_gnt: bus_req drops in the next cycle and the state goes to RESP.
  - bus_rvalid is not accepted in the same cycle as bus_gnt; the response is taken no earlier than the next cycle.
- RESP:
  - bus_req = 0.
  - On bus_rvalid: capture bus_rdata (reads only; writes leave the register unchanged), go to DONE.
- REQ/RESP common:
  - data_stall = 1.
  - The timeout counter increments every cycle in REQ or RESP and clears on entry to DONE or IDLE.
  - When the counter equals TIMEOUT_CYCLES-1 with no progress:
    - Abort: bus_req = 0, set fault.
    - Load ERR_RDATA into the rdata register, go to DONE.
- DONE:
  - data_stall = 0 for exactly one cycle; mem_rd_data = rdata register. The core advances its PC and writes back on this edge.
  - No new request is issued in DONE even though mem_rd/mem_wr are still asserted, so stores are never issued twice.
  - Next state is IDLE.
- mem_rd_data is the registered value in every state. The core's writeback only samples it in DONE.
- Stray bus_rvalid or bus_gnt in IDLE or DONE is ignored; no state change and no data capture.
- Latency:
  - Request seen at cycle 0; bus_req at cycle 1.
  - With gnt at cycle 1 and rvalid at cycle 2, DONE (stall low) is at cycle 3.
  - Minimum data access cost is 4 core cycles.
- Reset asserted mid-transaction:
  - bus_req drops asynchronously, the state returns to IDLE, and no completion is signalled.
  - An outstanding bus response after reset is ignored.
- fault is never cleared except by reset.

Test Plan:
- Aligned load, addr 0x0000_0010, gnt in cycle 1, rvalid with 0xCAFE_F00D in cycle 2 -> bus_req high only in cycle 1, bus_we=0, data_stall high in cycles 0–2 and low in cycle 3, mem_rd_data=0xCAFE_F00D in cycle 3.
- Store to 0x0000_0020 with data 0x1234_5678, gnt delayed 3 cycles, rvalid 2 cycles later -> bus_addr/bus_wdata stable throughout REQ, exactly one bus_req handshake, no re-request in DONE, stall low exactly one cycle.
- Load from 0x0000_0013 -> no bus_req, fault=1, mem_rd_data=ERR_RDATA, data_stall low in cycle 1.
- TIMEOUT_CYCLES=8, gnt never asserted -> bus_req drops after 8 cycles, fault=1, DONE with ERR_RDATA; a later stray rvalid is ignored.
- Reset pulsed low while in RESP -> bus_req=0 and data_stall=0 immediately, state IDLE, fault unchanged at 0.
- Back-to-back loads on consecutive instructions -> the second request starts only in the IDLE cycle after DONE; each access takes at least 4 cycles.

Source files
------------

// File: rtl/eka_dmem_bridge.sv
// Data-side bridge: turns the Eka core's single-cycle load/store into a registered
// req/gnt/rvalid bus transaction, stalling the core until it completes or times out.
module eka_dmem_bridge #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           mem_wr_data,
    input  logic                  mem_wr,
    input  logic                  mem_rd,
    output logic [31:0]           mem_rd_data,
    output logic                  data_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [31:0]           bus_rdata,
    output logic                  fault
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [31:0]      rdata;
    logic             access;
    logic             aligned;
    logic             expired;

    assign access      = mem_rd | mem_wr;
    assign aligned     = (data_addr[1:0] == 2'b00);
    // A late grant can carry the count past the last slot, so compare with >=.
    assign expired     = (tmo_cnt >= CNT_LAST);
    assign mem_rd_data = rdata;

    // The core is released while reset is held so it never waits on a dead access.
    always_comb begin
        data_stall = 1'b0;
        if (reset) begin
            data_stall = (state == REQ) || (state == RESP) || ((state == IDLE) && access);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (access) begin
                        if (aligned) begin
                            bus_addr  <= data_addr[ADDR_WIDTH-1:0];
                            bus_we    <= mem_wr;
                            bus_wdata <= mem_wr_data;
                            bus_req   <= 1'b1;
                            state     <= REQ;
                        end else begin
                            fault <= 1'b1;
                            rdata <= ERR_RDATA;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        tmo_cnt <= tmo_cnt + 1'b1;
                        state   <= RESP;
                    end else if (expired) begin
                        bus_req <= 1'b0;
                        fault   <= 1'b1;
                        rdata   <= ERR_RDATA;
                        tmo_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        if (!bus_we) begin
                            rdata <= bus_rdata;
                        end
                        tmo_cnt <= '0;
                        state   <= DONE;
                    end else if (expired) begin
                        fault   <= 1'b1;
                        rdata   <= ERR_RDATA;
                        tmo_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Core inputs still show the finished access here; never reissue it.
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eka_dmem_bridge.sv
// Self-checking bench for eka_dmem_bridge: directed cases plus randomized accesses
// checked cycle by cycle against a transaction-level timing model.
module tb_eka_dmem_bridge;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic [31:0] data_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rd_data;
    logic        data_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        fault;

    int          vec_cnt;
    int          err_cnt;
    logic [31:0] model_reg;
    logic        model_fault;

    eka_dmem_bridge #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (T),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_addr   (data_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_rd_data (mem_rd_data),
        .data_stall  (data_stall),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One core access. g = cycles of grant delay after bus_req rises (>= T means never),
    // r = cycles from grant to rvalid (>= 1).
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic rd,
                           input logic [31:0] wdata, input int g, input int r,
                           input logic [31:0] rdat, input logic rv_on_gnt, input logic stray);
        logic        mis;
        logic        ok;
        logic        exp_fault;
        logic        req_exp;
        logic [31:0] exp_rd;
        int          e;
        int          d;
        int          req_last;
        mis = (addr[1:0] != 2'b00);
        ok  = 1'b0;
        if (mis) begin
            d        = 1;
            req_last = 0;
        end else begin
            // Completion cycle if the bus answers in time, else the cycle the bridge gives up.
            if (g <= T - 1 && 1 + g + r <= T) begin
                ok = 1'b1;
                e  = 1 + g + r;
            end else if (g == T - 1 && r == 1) begin
                ok = 1'b1;
                e  = T + 1;
            end else begin
                e = (g == T - 1) ? T + 1 : T;
            end
            d        = e + 1;
            req_last = (g <= T - 1) ? 1 + g : T;
        end
        if (!ok)     exp_rd = ERR;
        else if (wr) exp_rd = model_reg;
        else         exp_rd = rdat;
        exp_fault = model_fault | !ok;

        for (int c = 0; c <= d; c++) begin
            @(posedge clk);
            #1;
            mem_rd      = rd;
            mem_wr      = wr;
            data_addr   = addr;
            mem_wr_data = wdata;
            bus_gnt     = (!mis && c == 1 + g) || (stray && c == d);
            bus_rvalid  = (!mis && c == 1 + g + r) || (rv_on_gnt && !mis && c == 1 + g)
                          || (stray && c == d);
            bus_rdata   = (!mis && c == 1 + g + r) ? rdat : $urandom();
            #1;
            req_exp = !mis && c >= 1 && c <= req_last;
            chk("data_stall", {31'b0, data_stall}, {31'b0, c < d});
            chk("bus_req", {31'b0, bus_req}, {31'b0, req_exp});
            if (req_exp) begin
                chk("bus_addr", bus_addr, addr);
                chk("bus_we", {31'b0, bus_we}, {31'b0, wr});
                chk("bus_wdata", bus_wdata, wdata);
            end
            if (c == d) begin
                chk("mem_rd_data", mem_rd_data, exp_rd);
                chk("fault", {31'b0, fault}, {31'b0, exp_fault});
            end
        end
        model_reg   = exp_rd;
        model_fault = exp_fault;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
    endtask

    task automatic idle_cycle(input logic stray);
        @(posedge clk);
        #1;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        data_addr  = $urandom();
        bus_gnt    = stray;
        bus_rvalid = stray;
        bus_rdata  = $urandom();
        #1;
        chk("idle_stall", {31'b0, data_stall}, 32'd0);
        chk("idle_req", {31'b0, bus_req}, 32'd0);
        chk("idle_rdata", mem_rd_data, model_reg);
        chk("idle_fault", {31'b0, fault}, {31'b0, model_fault});
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          g;
        int          r;
        vec_cnt     = 0;
        err_cnt     = 0;
        model_reg   = 32'h0;
        model_fault = 1'b0;
        reset       = 1'b0;
        data_addr   = 32'h0;
        mem_wr_data = 32'h0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_we", {31'b0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", mem_rd_data, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_stall", {31'b0, data_stall}, 32'd0);
        reset = 1'b1;

        // Reset pulsed while the access waits in RESP
        @(posedge clk);
        #1;
        mem_rd    = 1'b1;
        data_addr = 32'h0000_0040;
        #1;
        chk("mrst_stall0", {31'b0, data_stall}, 32'd1);
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        #1;
        chk("mrst_req1", {31'b0, bus_req}, 32'd1);
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        #1;
        chk("mrst_req2", {31'b0, bus_req}, 32'd0);
        chk("mrst_stall2", {31'b0, data_stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_req_async", {31'b0, bus_req}, 32'd0);
        chk("mrst_stall_async", {31'b0, data_stall}, 32'd0);
        chk("mrst_fault", {31'b0, fault}, 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        mem_rd     = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_AAAA;
        #1;
        chk("mrst_stall_after", {31'b0, data_stall}, 32'd0);
        idle_cycle(1'b0);

        // Directed: aligned load, back-to-back load, store, misaligned, timeout
        run_txn(32'h0000_0010, 1'b0, 1'b1, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_txn(32'h0000_0014, 1'b0, 1'b1, 32'h0, 1, 1, 32'h0BAD_CAFE, 1'b1, 1'b1);
        run_txn(32'h0000_0020, 1'b1, 1'b0, 32'h1234_5678, 3, 2, 32'hFFFF_0000, 1'b0, 1'b1);
        idle_cycle(1'b1);
        run_txn(32'h0000_0013, 1'b0, 1'b1, 32'h0, 0, 1, 32'h0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        run_txn(32'h0000_0030, 1'b0, 1'b1, 32'h0, 99, 1, 32'h0, 1'b0, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            a = $urandom();
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            else                           a[1:0] = 2'b00;
            sel = $urandom_range(0, 2);
            g   = $urandom_range(0, 9);
            if (g < 6)       g = $urandom_range(0, 3);
            else if (g < 9)  g = $urandom_range(4, 8);
            else             g = 99;
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 3);
            run_txn(a, sel != 0, sel != 1, $urandom(), g, r, $urandom(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = $urandom_range(0, 2); k > 0; k--) idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
